// File: rtl/f_pc_ctrl.sv
// Fetch-stage PC controller: sequences the fetch address, applies D-stage redirects
// (branch, j/jal, jr/jalr) and parks a redirect target while imem back-pressures.
module f_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic [1:0]  i_npcOp,
    input  logic        i_jumpEn_of_B,
    input  logic [31:0] i_D_pc,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_index26,
    input  logic [31:0] i_jrTarget,
    input  logic        i_imem_ready,
    output logic        o_imem_req,
    output logic [31:0] o_F_pc,
    output logic        o_fetch_fire,
    output logic        o_excAdEL
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } stateT;

    stateT       state, stateNext;
    logic [31:0] pc, pcNext;
    logic [31:0] pending, pendingNext;
    logic [31:0] dPcPlus4;
    logic [31:0] target;
    logic        redirect;

    assign o_imem_req   = (state != BOOT) && !i_stall;
    assign o_fetch_fire = o_imem_req && i_imem_ready;
    assign o_F_pc       = pc;
    assign o_excAdEL    = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);

    assign dPcPlus4 = i_D_pc + 32'd4;

    always_comb begin
        target = dPcPlus4;
        unique case (i_npcOp)
            2'd1:    target = dPcPlus4 + {{14{i_imm16[15]}}, i_imm16, 2'b00};
            2'd2:    target = {dPcPlus4[31:28], i_index26, 2'b00};
            2'd3:    target = i_jrTarget;
            default: target = dPcPlus4;
        endcase
    end

    // Branch-taken flag only qualifies conditional branches; jumps always redirect.
    assign redirect = (state == RUN) && !i_stall &&
                      (((i_npcOp == 2'd1) && i_jumpEn_of_B) || (i_npcOp == 2'd2) || (i_npcOp == 2'd3));

    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        pendingNext = pending;
        unique case (state)
            BOOT: stateNext = RUN;
            RUN: begin
                if (o_fetch_fire) begin
                    pcNext = redirect ? target : pc + 32'd4;
                end else if (redirect) begin
                    // Delay slot at pc still has to be fetched before the target.
                    pendingNext = target;
                    stateNext   = HOLD;
                end
            end
            HOLD: begin
                if (o_fetch_fire) begin
                    pcNext    = pending;
                    stateNext = RUN;
                end
            end
            default: stateNext = BOOT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            pending <= 32'd0;
        end else begin
            state   <= stateNext;
            pc      <= pcNext;
            pending <= pendingNext;
        end
    end

endmodule

// File: doc/f_pc_ctrl.md
F_PC_CTRL -- requirements
Module: F_PC_CTRL

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 SHALL have parameter IMEM_LO, default 32'h0000_3000, lowest legal fetch address.
REQ-003 SHALL have parameter IMEM_HI, default 32'h0000_6FFC, highest legal fetch address.
REQ-004 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_stall  input  1  D-stage hazard stall; D instruction not resolvable this cycle.
REQ-007 SHALL have port i_npcOp  input  2  D-stage next-PC kind: 0 sequential, 1 conditional branch, 2 j/jal, 3 jr/jalr.
REQ-008 SHALL have port i_jumpEn_of_B  input  1  branch-taken flag from D-stage comparator.
REQ-009 SHALL have port i_D_pc  input  32  PC of instruction in D.
REQ-010 SHALL have port i_imm16  input  16  branch offset field.
REQ-011 SHALL have port i_index26  input  26  j/jal index field.
REQ-012 SHALL have port i_jrTarget  input  32  forwarded rs value for jr/jalr.
REQ-013 SHALL have port i_imem_ready  input  1  instruction memory accepts request.
REQ-014 SHALL have port o_imem_req  output  1  fetch request.
REQ-015 SHALL have port o_F_pc  output  32  current fetch address (PC register).
REQ-016 SHALL have port o_fetch_fire  output  1  request accepted this cycle; F/D register loads.
REQ-017 SHALL have port o_excAdEL  output  1  o_F_pc misaligned or outside [IMEM_LO, IMEM_HI].

Function
REQ-018 SHALL implement states BOOT, RUN, HOLD (2-bit encoded).
REQ-019 SHALL drive o_imem_req = (state != BOOT) && !i_stall; o_fetch_fire = o_imem_req && i_imem_ready (combinational).
REQ-020 SHALL compute branch target = i_D_pc + 4 + (sign_extend(i_imm16) << 2), 32-bit wrap-around, no overflow flag.
REQ-021 SHALL compute j target = {(i_D_pc + 4)[31:28], i_index26, 2'b00}; jr target = i_jrTarget unmodified.
REQ-022 SHALL define redirect = state==RUN && !i_stall && (i_npcOp==1 && i_jumpEn_of_B || i_npcOp==2 || i_npcOp==3); i_jumpEn_of_B ignored for npcOp != 1.
REQ-023 SHALL in BOOT hold PC, then enter RUN on the next edge unconditionally.
REQ-024 SHALL in RUN, on fire with redirect: PC <= target (delay slot at current PC is the fetched instruction).
REQ-025 SHALL in RUN, on fire without redirect: PC <= PC + 4 (32-bit wrap).
REQ-026 SHALL in RUN, redirect without fire: latch target into pending register, hold PC, enter HOLD.
REQ-027 SHALL in RUN, no fire and no redirect: hold PC and state.
REQ-028 SHALL in HOLD ignore i_npcOp/i_jumpEn_of_B; on fire PC <= pending, return to RUN; otherwise hold.
REQ-029 SHALL hold PC, pending and state whenever i_stall=1 (no request issued).
REQ-030 SHALL assert o_excAdEL combinationally when o_F_pc[1:0]!=0 or o_F_pc<IMEM_LO or o_F_pc>IMEM_HI; PC sequencing unaffected.
REQ-031 SHALL present all outputs glitch-free from registers except o_imem_req, o_fetch_fire, o_excAdEL.

Reset
REQ-032 SHALL on i_rst_n=0, asynchronously: PC=RESET_PC, pending=0, state=BOOT; hence o_imem_req=0, o_fetch_fire=0, o_excAdEL=0.
REQ-033 SHALL on reset mid-HOLD discard pending target; first fetch after reset is RESET_PC.
REQ-034 SHALL release synchronously: first request issued the cycle after the first edge with i_rst_n=1.

Verification
REQ-035 SHALL cover: reset release, i_imem_ready=1, npcOp=0 -> o_F_pc 0x3000, 0x3004, 0x3008 on consecutive cycles; o_imem_req low during BOOT.
REQ-036 SHALL cover: D_pc=0x3000, npcOp=1, jumpEn=1, imm16=0xFFFF, fire -> delay slot 0x3004 fetched, next PC 0x3000; same with jumpEn=0 -> 0x3008.
REQ-037 SHALL cover: npcOp=2, D_pc=0x3010, index26=0x0000C40 -> next PC 0x0000_3100; npcOp=3, jrTarget=0x3002 -> o_excAdEL=1 on that fetch.
REQ-038 SHALL cover: branch taken with i_imem_ready=0 for 3 cycles -> state HOLD, PC holds delay slot, then fire -> PC = latched target; D inputs changed during HOLD have no effect.
REQ-039 SHALL cover: i_stall=1 for 2 cycles with redirect inputs set -> o_imem_req=0, PC unchanged, no redirect taken until stall drops.
REQ-040 SHALL cover: i_rst_n asserted mid-HOLD -> immediate PC=0x3000, state BOOT, pending discarded.
